spi_scan_ctl: RTL and testbench

SPI_SCAN_CTL -- requirements
Module: spi_scan_ctl

---
 rtl/spi_scan_ctl.sv | 122 ++++++++++++
 tb/tb_spi_scan_ctl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_scan_ctl.sv
// SPI ADC scan controller: sequences command, dead and capture phases
// of each frame and steps through the channels of a scan.
module spi_scan_ctl #(
    parameter int CMD_BITS     = 6,
    parameter int NULL_BITS    = 1,
    parameter int ADC_WIDTH    = 10,
    parameter int NUM_CHANNELS = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       cont,
    output logic       cs,
    output logic       pts_en,
    output logic       stp_en,
    output logic       chan_en,
    output logic [4:0] chansel,
    output logic [2:0] chan_idx,
    output logic       busy,
    output logic       frame_done,
    output logic       scan_done
);

    localparam logic [15:0] FRAME_END = 16'(CMD_BITS + NULL_BITS + ADC_WIDTH - 1);
    localparam logic [15:0] CMD_END   = 16'(CMD_BITS);
    localparam logic [15:0] DATA_BEG  = 16'(CMD_BITS + NULL_BITS);
    localparam logic [15:0] GAP_END   = 16'(GAP_CYCLES - 1);
    localparam logic [2:0]  LAST_CH   = 3'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  chan_q, chan_d;
    // Set while the gap that follows the scan's last channel is running;
    // chan_idx alone cannot tell, since it has already advanced in GAP.
    logic        last_q, last_d;

    // State, counter, channel and last-frame flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic for the frame/gap sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                chan_d = '0;
                last_d = 1'b0;
                if (start) begin
                    state_d = FRAME;
                end
            end
            FRAME: begin
                if (cnt_q == FRAME_END) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    last_d  = (chan_q == LAST_CH);
                    if (chan_q != LAST_CH) begin
                        chan_d = chan_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d  = '0;
                    last_d = 1'b0;
                    if (!last_q) begin
                        state_d = FRAME;
                    end else begin
                        chan_d  = '0;
                        state_d = cont ? FRAME : IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                chan_d  = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        cs         = (state_q != FRAME);
        chan_en    = cs;
        pts_en     = (state_q == FRAME) && (cnt_q < CMD_END);
        stp_en     = (state_q == FRAME) && (cnt_q >= DATA_BEG);
        busy       = (state_q != IDLE);
        frame_done = (state_q == GAP) && (cnt_q == 16'd0);
        scan_done  = frame_done && last_q;
        chan_idx   = chan_q;
        chansel    = {2'b11, chan_q};
    end

endmodule

// File: tb/tb_spi_scan_ctl.sv
// Scoreboard bench for spi_scan_ctl across five parameter sets.
// Each finished frame is compared against a queued expected record.
module tb_spi_scan_ctl;

    logic clk;
    logic [4:0] rn, st, ct;
    logic [4:0] cs_w, pts_w, stp_w, cen_w, busy_w, fd_w, sd_w;
    logic [4:0] sel_w [5];
    logic [2:0] idx_w [5];

    int checks = 0;
    int errors = 0;

    int cmds [5] = '{6, 6, 6, 6, 5};
    int nuls [5] = '{1, 1, 1, 1, 2};
    int gaps [5] = '{1, 2, 1, 1, 1};

    typedef struct {
        int         inst;
        logic [4:0] sel;
        logic       sd;
        int         len;
    } rec_t;

    rec_t sb [$];

    int pos [5];
    int gapc [5];
    int fd_cnt [5];
    logic [4:0] sel_seen [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_scan_ctl u0 (
        .clk(clk), .n_rst(rn[0]), .start(st[0]), .cont(ct[0]),
        .cs(cs_w[0]), .pts_en(pts_w[0]), .stp_en(stp_w[0]),
        .chan_en(cen_w[0]), .chansel(sel_w[0]), .chan_idx(idx_w[0]),
        .busy(busy_w[0]), .frame_done(fd_w[0]), .scan_done(sd_w[0])
    );

    spi_scan_ctl #(.NUM_CHANNELS(4), .GAP_CYCLES(2)) u1 (
        .clk(clk), .n_rst(rn[1]), .start(st[1]), .cont(ct[1]),
        .cs(cs_w[1]), .pts_en(pts_w[1]), .stp_en(stp_w[1]),
        .chan_en(cen_w[1]), .chansel(sel_w[1]), .chan_idx(idx_w[1]),
        .busy(busy_w[1]), .frame_done(fd_w[1]), .scan_done(sd_w[1])
    );

    spi_scan_ctl #(.NUM_CHANNELS(3)) u2 (
        .clk(clk), .n_rst(rn[2]), .start(st[2]), .cont(ct[2]),
        .cs(cs_w[2]), .pts_en(pts_w[2]), .stp_en(stp_w[2]),
        .chan_en(cen_w[2]), .chansel(sel_w[2]), .chan_idx(idx_w[2]),
        .busy(busy_w[2]), .frame_done(fd_w[2]), .scan_done(sd_w[2])
    );

    spi_scan_ctl #(.NUM_CHANNELS(2)) u3 (
        .clk(clk), .n_rst(rn[3]), .start(st[3]), .cont(ct[3]),
        .cs(cs_w[3]), .pts_en(pts_w[3]), .stp_en(stp_w[3]),
        .chan_en(cen_w[3]), .chansel(sel_w[3]), .chan_idx(idx_w[3]),
        .busy(busy_w[3]), .frame_done(fd_w[3]), .scan_done(sd_w[3])
    );

    spi_scan_ctl #(.CMD_BITS(5), .NULL_BITS(2), .ADC_WIDTH(12)) u4 (
        .clk(clk), .n_rst(rn[4]), .start(st[4]), .cont(ct[4]),
        .cs(cs_w[4]), .pts_en(pts_w[4]), .stp_en(stp_w[4]),
        .chan_en(cen_w[4]), .chansel(sel_w[4]), .chan_idx(idx_w[4]),
        .busy(busy_w[4]), .frame_done(fd_w[4]), .scan_done(sd_w[4])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frames(int i, int n, int nch, int len);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r.inst = i;
            r.sel  = {2'b11, 3'(k % nch)};
            r.sd   = ((k % nch) == nch - 1);
            r.len  = len;
            sb.push_back(r);
        end
    endtask

    task automatic pulse_start(int i);
        @(negedge clk);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int n;
        n = 0;
        while (busy_w[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_fd(int i, int target);
        int n;
        n = 0;
        while (fd_cnt[i] < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("fd_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_cs_low(int i);
        int n;
        n = 0;
        while (cs_w[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cs_timeout", 32'(n < 100), 32'd1);
    endtask

    // Per-instance frame monitor feeding the scoreboard.
    always @(negedge clk) begin
        rec_t r;
        for (int i = 0; i < 5; i++) begin
            if (!rn[i]) begin
                pos[i]  = 0;
                gapc[i] = 0;
            end else if (!cs_w[i]) begin
                if (pos[i] == 0 && gapc[i] > 0) begin
                    chk("gap_len", 32'(gapc[i]), 32'(gaps[i]));
                end
                gapc[i] = 0;
                chk("pts_pos", 32'(pts_w[i]), 32'(pos[i] < cmds[i]));
                chk("stp_pos", 32'(stp_w[i]),
                    32'(pos[i] >= cmds[i] + nuls[i]));
                sel_seen[i] = sel_w[i];
                pos[i]++;
            end else begin
                if (pts_w[i] || stp_w[i]) begin
                    chk("en_off", {30'd0, pts_w[i], stp_w[i]}, 32'd0);
                end
                if (busy_w[i]) gapc[i]++;
                else gapc[i] = 0;
                if (fd_w[i]) begin
                    fd_cnt[i]++;
                    if (sb.size() == 0) begin
                        chk("sb_unexpected", 32'(i), 32'hffff);
                    end else begin
                        r = sb.pop_front();
                        chk("sb_inst", 32'(i), 32'(r.inst));
                        chk("sb_len", 32'(pos[i]), 32'(r.len));
                        chk("sb_sel", 32'(sel_seen[i]), 32'(r.sel));
                        chk("sb_sd", 32'(sd_w[i]), 32'(r.sd));
                    end
                    pos[i] = 0;
                end
            end
            if (sd_w[i] && !fd_w[i]) begin
                chk("sd_alone", 32'(i), 32'hffff);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 5; i++) begin
            pos[i]    = 0;
            gapc[i]   = 0;
            fd_cnt[i] = 0;
        end
        rn = '1;
        st = '0;
        ct = '0;
        #3;
        rn = '0;
        #1;
        chk("rst_cs", 32'(cs_w), 32'h1f);
        chk("rst_cen", 32'(cen_w), 32'h1f);
        chk("rst_pts", 32'(pts_w), 32'h0);
        chk("rst_stp", 32'(stp_w), 32'h0);
        chk("rst_busy", 32'(busy_w), 32'h0);
        chk("rst_fd", 32'(fd_w | sd_w), 32'h0);
        chk("rst_sel", 32'(sel_w[0]), 32'h18);
        chk("rst_idx", 32'(idx_w[0]), 32'h0);
        repeat (3) @(negedge clk);
        rn = '1;
        repeat (5) @(negedge clk);
        chk("idle_hold", 32'(busy_w), 32'h0);

        push_frames(0, 1, 1, 17);
        pulse_start(0);
        chk("u0_busy", 32'(busy_w[0]), 32'h1);
        wait_idle(0);
        chk("u0_frames", 32'(fd_cnt[0]), 32'd1);

        push_frames(1, 4, 4, 17);
        pulse_start(1);
        wait_idle(1);
        chk("u1_frames", 32'(fd_cnt[1]), 32'd4);

        ct[2] = 1'b1;
        push_frames(2, 6, 3, 17);
        pulse_start(2);
        wait_fd(2, 4);
        wait_cs_low(2);
        chk("u2_f5_ch", 32'(idx_w[2]), 32'd1);
        ct[2] = 1'b0;
        wait_idle(2);
        chk("u2_frames", 32'(fd_cnt[2]), 32'd6);

        push_frames(3, 1, 2, 17);
        pulse_start(3);
        wait_fd(3, 1);
        wait_cs_low(3);
        repeat (9) @(negedge clk);
        chk("pre_rst_idx", 32'(idx_w[3]), 32'd1);
        rn[3] = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(cs_w[3]), 32'd1);
        chk("mid_rst_busy", 32'(busy_w[3]), 32'd0);
        chk("mid_rst_idx", 32'(idx_w[3]), 32'd0);
        chk("mid_rst_en", {30'd0, pts_w[3], stp_w[3]}, 32'd0);
        chk("mid_rst_sel", 32'(sel_w[3]), 32'h18);
        @(negedge clk);
        rn[3] = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy_w[3]), 32'd0);
        chk("post_rst_fd", 32'(fd_cnt[3]), 32'd1);

        push_frames(3, 4, 2, 17);
        @(negedge clk);
        st[3] = 1'b1;
        @(negedge clk);
        chk("u3_busy", 32'(busy_w[3]), 32'd1);
        wait_idle(3);
        n = 0;
        while (!busy_w[3] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("u3_idle_gap", 32'(n), 32'd1);
        st[3] = 1'b0;
        wait_idle(3);
        chk("u3_frames", 32'(fd_cnt[3]), 32'd5);

        push_frames(4, 1, 1, 19);
        pulse_start(4);
        wait_idle(4);
        chk("u4_frames", 32'(fd_cnt[4]), 32'd1);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("end_busy", 32'(busy_w), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
